// File: rtl/wave_grid_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_grid_if
// Brief    : Host-side handshake, control and probe bundle for wave_grid_solver.
//            The master drives control and initial values; the slave (the
//            solver) returns load/solve status and the probe stream.
// Revision : 1.0  initial release
// ============================================================================
interface wave_grid_if #(
    parameter int WIDTH = 18
) ();
    logic                    enable;
    logic                    reload;
    logic signed [WIDTH-1:0] rho;
    logic                    init_valid;
    logic signed [WIDTH-1:0] init_data;
    logic                    init_ready;
    logic                    busy;
    logic signed [WIDTH-1:0] probe_out;
    logic                    probe_valid;
    logic [15:0]             step_count;

    modport master (
        output enable, reload, rho, init_valid, init_data,
        input  init_ready, busy, probe_out, probe_valid, step_count
    );

    modport slave (
        input  enable, reload, rho, init_valid, init_data,
        output init_ready, busy, probe_out, probe_valid, step_count
    );
endinterface
`default_nettype wire

// File: rtl/wave_grid_solver.sv
`default_nettype none
// ============================================================================
// Module   : wave_grid_solver
// Brief    : Time-multiplexed finite-difference wave-equation solver for a
//            ROWS x COLS membrane. One shared update datapath sweeps one node
//            per clock; two banks ping-pong between u_cur and u_prev.
// Revision : 1.0  initial release
// ============================================================================
module wave_grid_solver #(
    parameter int ROWS       = 6,
    parameter int COLS       = 6,
    parameter int WIDTH      = 18,
    parameter int DAMP_SHIFT = 10,
    parameter int PROBE_ROW  = 3,
    parameter int PROBE_COL  = 3
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    wave_grid_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = WIDTH + 3;       // Laplacian width
    localparam int SW = WIDTH + 4;       // update sum width
    localparam int PW = 2 * WIDTH + 3;   // full rho*lap product width

    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] PROBE_IDX = IW'(PROBE_ROW * COLS + PROBE_COL);
    localparam logic [IW-1:0] COLS_IW   = IW'(COLS);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (WIDTH - 1)));

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_SOLVE = 1'b1
    } state_t;

    state_t                  state_q,       state_d;
    logic [IW-1:0]           idx_q,         idx_d;
    logic [RW-1:0]           row_q,         row_d;
    logic [CW-1:0]           col_q,         col_d;
    logic                    bank_sel_q,    bank_sel_d;
    logic [15:0]             step_count_q,  step_count_d;
    logic signed [WIDTH-1:0] probe_out_q,   probe_out_d;
    logic                    probe_valid_q, probe_valid_d;
    logic signed [WIDTH-1:0] bank_a_q [N];
    logic signed [WIDTH-1:0] bank_a_d [N];
    logic signed [WIDTH-1:0] bank_b_q [N];
    logic signed [WIDTH-1:0] bank_b_d [N];

    // Sweep position after the current node; row/col wrap together with idx.
    logic [IW-1:0] idx_nxt;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    // Datapath operands and intermediate values.
    logic [IW-1:0]           idx_l, idx_r, idx_u, idx_d_nb;
    logic signed [WIDTH-1:0] u_c, u_p, u_l, u_r, u_u, u_d;
    logic signed [LW-1:0]    lap;
    logic signed [PW-1:0]    prod_full;
    logic signed [SW-1:0]    prod;
    logic signed [WIDTH:0]   vel;
    logic signed [SW-1:0]    sum;
    logic signed [WIDTH-1:0] u_next;

    // Raster-order successor of the current sweep position.
    always_comb begin
        idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        row_nxt = row_q;
        col_nxt = col_q + 1'b1;
        if (col_q == LAST_COL) begin
            col_nxt = '0;
            row_nxt = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
    end

    // Neighbour reads from u_cur; off-grid neighbours are a fixed zero
    // boundary. Indices fall back to idx_q so every array read stays in range.
    always_comb begin
        idx_l    = (col_q == '0)       ? idx_q : idx_q - 1'b1;
        idx_r    = (col_q == LAST_COL) ? idx_q : idx_q + 1'b1;
        idx_u    = (row_q == '0)       ? idx_q : idx_q - COLS_IW;
        idx_d_nb = (row_q == LAST_ROW) ? idx_q : idx_q + COLS_IW;

        u_c = bank_sel_q ? bank_b_q[idx_q] : bank_a_q[idx_q];
        u_p = bank_sel_q ? bank_a_q[idx_q] : bank_b_q[idx_q];
        u_l = (col_q == '0)       ? '0 : (bank_sel_q ? bank_b_q[idx_l]    : bank_a_q[idx_l]);
        u_r = (col_q == LAST_COL) ? '0 : (bank_sel_q ? bank_b_q[idx_r]    : bank_a_q[idx_r]);
        u_u = (row_q == '0)       ? '0 : (bank_sel_q ? bank_b_q[idx_u]    : bank_a_q[idx_u]);
        u_d = (row_q == LAST_ROW) ? '0 : (bank_sel_q ? bank_b_q[idx_d_nb] : bank_a_q[idx_d_nb]);
    end

    // Single-cycle leapfrog update with velocity damping and output saturation.
    always_comb begin
        lap       = LW'(u_l) + LW'(u_r) + LW'(u_u) + LW'(u_d) - (LW'(u_c) <<< 2);
        prod_full = PW'(bus.rho) * PW'(lap);
        prod      = SW'(prod_full >>> (WIDTH - 1));
        vel       = (WIDTH + 1)'(u_c) - (WIDTH + 1)'(u_p);
        sum       = prod + (SW'(u_c) <<< 1) - SW'(u_p) - SW'(vel >>> DAMP_SHIFT);
        if (sum > SAT_MAX) begin
            u_next = SAT_MAX[WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            u_next = SAT_MIN[WIDTH-1:0];
        end else begin
            u_next = sum[WIDTH-1:0];
        end
    end

    // Next-state: load handshake, solve sweep, step bookkeeping and reload.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        col_d         = col_q;
        bank_sel_d    = bank_sel_q;
        step_count_d  = step_count_q;
        probe_out_d   = probe_out_q;
        probe_valid_d = 1'b0;
        bank_a_d      = bank_a_q;
        bank_b_d      = bank_b_q;

        if (bus.reload) begin
            state_d      = S_LOAD;
            idx_d        = '0;
            row_d        = '0;
            col_d        = '0;
            bank_sel_d   = 1'b0;
            step_count_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.init_valid) begin
                        // Same value in both banks: zero initial velocity.
                        bank_a_d[idx_q] = bus.init_data;
                        bank_b_d[idx_q] = bus.init_data;
                        idx_d = idx_nxt;
                        row_d = row_nxt;
                        col_d = col_nxt;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_SOLVE;
                        end
                    end
                end
                S_SOLVE: begin
                    if (bus.enable) begin
                        // u_prev[idx] is read only by node idx, so overwrite in place.
                        if (bank_sel_q) begin
                            bank_a_d[idx_q] = u_next;
                        end else begin
                            bank_b_d[idx_q] = u_next;
                        end
                        idx_d = idx_nxt;
                        row_d = row_nxt;
                        col_d = col_nxt;
                        if (idx_q == LAST_IDX) begin
                            bank_sel_d    = ~bank_sel_q;
                            step_count_d  = step_count_q + 16'd1;
                            probe_valid_d = 1'b1;
                            if (PROBE_IDX == LAST_IDX) begin
                                probe_out_d = u_next;
                            end else begin
                                probe_out_d = bank_sel_q ? bank_a_q[PROBE_IDX] : bank_b_q[PROBE_IDX];
                            end
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    // State, counters, probe and bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            row_q         <= '0;
            col_q         <= '0;
            bank_sel_q    <= 1'b0;
            step_count_q  <= '0;
            probe_out_q   <= '0;
            probe_valid_q <= 1'b0;
            bank_a_q      <= '{default: '0};
            bank_b_q      <= '{default: '0};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bank_sel_q    <= bank_sel_d;
            step_count_q  <= step_count_d;
            probe_out_q   <= probe_out_d;
            probe_valid_q <= probe_valid_d;
            bank_a_q      <= bank_a_d;
            bank_b_q      <= bank_b_d;
        end
    end

    assign bus.init_ready  = (state_q == S_LOAD);
    assign bus.busy        = (state_q == S_SOLVE);
    assign bus.probe_out   = probe_out_q;
    assign bus.probe_valid = probe_valid_q;
    assign bus.step_count  = step_count_q;
endmodule
`default_nettype wire

// File: tb/tb_wave_grid_solver.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_grid_solver
// Brief    : Self-checking bench for wave_grid_solver on a 4x4 grid. Two
//            instances share stimulus and probe nodes (1,1) and (1,2).
// Revision : 1.0  initial release
// ============================================================================
module tb_wave_grid_solver;
    localparam int W = 18;
    localparam int N = 16;

    typedef struct {
        logic [W-1:0] init11;   // value of node (1,1); all other nodes load 0
        logic [W-1:0] rho;
        logic [W-1:0] a1;       // node (1,1) after step 1
        logic [W-1:0] b1;       // node (1,2) after step 1
        logic [W-1:0] a2;       // node (1,1) after step 2
        logic [W-1:0] b2;       // node (1,2) after step 2
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         reload = 1'b0;
    logic         init_valid = 1'b0;
    logic [W-1:0] rho = '0;
    logic [W-1:0] init_data = '0;
    int           checks = 0;
    int           errors = 0;
    vec_t         vecs [5];

    wave_grid_if #(.WIDTH(W)) bus_a ();
    wave_grid_if #(.WIDTH(W)) bus_b ();

    assign bus_a.enable     = enable;
    assign bus_a.reload     = reload;
    assign bus_a.rho        = rho;
    assign bus_a.init_valid = init_valid;
    assign bus_a.init_data  = init_data;
    assign bus_b.enable     = enable;
    assign bus_b.reload     = reload;
    assign bus_b.rho        = rho;
    assign bus_b.init_valid = init_valid;
    assign bus_b.init_data  = init_data;

    wave_grid_solver #(
        .ROWS(4), .COLS(4), .WIDTH(W), .DAMP_SHIFT(10), .PROBE_ROW(1), .PROBE_COL(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    wave_grid_solver #(
        .ROWS(4), .COLS(4), .WIDTH(W), .DAMP_SHIFT(10), .PROBE_ROW(1), .PROBE_COL(2)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check({tag, "_reload_ready"}, W'(bus_a.init_ready), W'(1));
        check({tag, "_reload_busy"}, W'(bus_a.busy), W'(0));
        check({tag, "_reload_count"}, W'(bus_a.step_count), W'(0));
    endtask

    // Loads node (1,1)=init11, others 0; optionally with random valid gaps.
    task automatic load_grid(input string tag, input logic [W-1:0] init11, input bit rand_valid);
        int   accepted = 0;
        int   guard = 0;
        logic ready_ok = 1'b1;
        logic busy_ok = 1'b1;
        while (accepted < N && guard < 400) begin
            init_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            init_data  = (accepted == 5) ? init11 : '0;
            if (bus_a.init_ready !== 1'b1) ready_ok = 1'b0;
            if (bus_a.busy !== 1'b0) busy_ok = 1'b0;
            tick();
            guard++;
            if (init_valid) accepted++;
        end
        init_valid = 1'b0;
        check({tag, "_load_words"}, W'(accepted), W'(N));
        check({tag, "_ready_during_load"}, W'(ready_ok && busy_ok), W'(1));
        check({tag, "_ready_after_load"}, W'(bus_a.init_ready), W'(0));
        check({tag, "_busy_after_load"}, W'(bus_a.busy), W'(1));
    endtask

    // Runs until the next probe pulse; pause drops enable for 5 cycles at idx 7.
    task automatic run_step(input string tag, input int exp_cycles, input bit pause,
                            input logic [W-1:0] exp_a, input logic [W-1:0] exp_b,
                            input logic [15:0] exp_cnt);
        int cyc = 0;
        bit seen = 1'b0;
        while (cyc < 64 && !seen) begin
            enable = !(pause && cyc >= 7 && cyc < 12);
            tick();
            cyc++;
            seen = bus_a.probe_valid;
        end
        enable = 1'b1;
        check({tag, "_cycles"}, W'(cyc), W'(exp_cycles));
        check({tag, "_probe_11"}, bus_a.probe_out, exp_a);
        check({tag, "_probe_12"}, bus_b.probe_out, exp_b);
        check({tag, "_step_count"}, W'(bus_a.step_count), W'(exp_cnt));
    endtask

    initial begin
        vecs[0] = '{18'h00000, 18'h04000, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
        vecs[1] = '{18'h08000, 18'h04000, 18'h04000, 18'h01000, 18'h3E810, 18'h01FFC};
        vecs[2] = '{18'h08000, 18'h00000, 18'h08000, 18'h00000, 18'h08000, 18'h00000};
        vecs[3] = '{18'h38000, 18'h04000, 18'h3C000, 18'h3F000, 18'h017F0, 18'h3E004};
        vecs[4] = '{18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h20001, 18'h1FFFF, 18'h20000};

        #2;
        check("rst_ready", W'(bus_a.init_ready), W'(1));
        check("rst_busy", W'(bus_a.busy), W'(0));
        check("rst_probe", bus_a.probe_out, W'(0));
        check("rst_valid", W'(bus_a.probe_valid), W'(0));
        check("rst_count", W'(bus_a.step_count), W'(0));
        tick();
        rst_n = 1'b1;
        enable = 1'b1;

        // Table-driven two-step runs.
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            do_reload(tag);
            rho = vecs[v].rho;
            load_grid(tag, vecs[v].init11, 1'b0);
            run_step({tag, "_s1"}, N, 1'b0, vecs[v].a1, vecs[v].b1, 16'd1);
            run_step({tag, "_s2"}, N, 1'b0, vecs[v].a2, vecs[v].b2, 16'd2);
        end

        // Pause in step 1, random-valid load handshake.
        do_reload("pause");
        rho = 18'h04000;
        load_grid("pause", 18'h08000, 1'b1);
        run_step("pause_s1", N + 5, 1'b1, 18'h04000, 18'h01000, 16'd1);
        run_step("pause_s2", N, 1'b0, 18'h3E810, 18'h01FFC, 16'd2);

        // Reload mid-step 3: counters clear, probe_out holds.
        for (int i = 0; i < 5; i++) tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("mid_reload_ready", W'(bus_a.init_ready), W'(1));
        check("mid_reload_busy", W'(bus_a.busy), W'(0));
        check("mid_reload_count", W'(bus_a.step_count), W'(0));
        check("mid_reload_valid", W'(bus_a.probe_valid), W'(0));
        check("mid_reload_probe_held", bus_a.probe_out, 18'h3E810);

        // Asynchronous reset at idx 9 of step 1.
        load_grid("rst", 18'h08000, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", W'(bus_a.init_ready), W'(1));
        check("async_rst_busy", W'(bus_a.busy), W'(0));
        check("async_rst_probe", bus_a.probe_out, W'(0));
        check("async_rst_valid", W'(bus_a.probe_valid), W'(0));
        check("async_rst_count", W'(bus_a.step_count), W'(0));
        tick();
        rst_n = 1'b1;
        do_reload("rerun");
        load_grid("rerun", 18'h08000, 1'b0);
        run_step("rerun_s1", N, 1'b0, 18'h04000, 18'h01000, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
